// File: rtl/text_line_renderer_pkg.sv
// Shared constants for the text line renderer: glyph geometry, character
// code width, font ROM address width, coordinate arithmetic width and the
// code the character buffers fill with on reset.
package text_line_renderer_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int CODE_W  = 7;
    localparam int ROM_AW  = 11;
    // One bit wider than the 10-bit pixel coordinates.
    localparam int COORD_W = 11;

    localparam logic [CODE_W-1:0] FILL_CODE = 7'h20;

    // Font ROM address: character code in the upper bits, glyph row below.
    function automatic logic [ROM_AW-1:0] rom_addr(input logic [CODE_W-1:0] code,
                                                   input logic [3:0]        row);
        return {code, row};
    endfunction

endpackage

// File: rtl/text_line_renderer_glyph_rom.sv
// glyph_rom: 8x16 font ROM covering the digits, ':', '.', 'A', 'P' and 'M'.
// The address is registered when en_i is high. The row data is decoded
// combinationally from the registered address. Undefined codes read blank.
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset (clears the address register)
//   en_i     address load enable (pixel tick)
//   addr_i   {code[6:0], row[3:0]}
//   data_o   glyph row bits, MSB = leftmost column
module glyph_rom
    import text_line_renderer_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [GLYPH_W-1:0] data_o
);

    logic [ROM_AW-1:0] addr_q;
    logic [127:0]      glyph_s;
    logic [127:0]      row_sel_s;

    // Address register: the first pipeline stage of the renderer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= '0;
        end else if (en_i) begin
            addr_q <= addr_i;
        end else begin
            addr_q <= addr_q;
        end
    end

    // Glyph bitmap lookup: byte 0 (top row) sits in the most significant bits.
    always_comb begin
        glyph_s = 128'h0;
        case (addr_q[10:4])
            7'h30:   glyph_s = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000; // 0
            7'h31:   glyph_s = 128'h0000_1838_7818_1818_1818_187E_0000_0000; // 1
            7'h32:   glyph_s = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000; // 2
            7'h33:   glyph_s = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000; // 3
            7'h34:   glyph_s = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000; // 4
            7'h35:   glyph_s = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000; // 5
            7'h36:   glyph_s = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000; // 6
            7'h37:   glyph_s = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000; // 7
            7'h38:   glyph_s = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000; // 8
            7'h39:   glyph_s = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000; // 9
            7'h3A:   glyph_s = 128'h0000_0000_1818_0000_0018_1800_0000_0000; // :
            7'h2E:   glyph_s = 128'h0000_0000_0000_0000_0018_1800_0000_0000; // .
            7'h41:   glyph_s = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000; // A
            7'h50:   glyph_s = 128'h0000_FC66_6666_7C60_6060_60F0_0000_0000; // P
            7'h4D:   glyph_s = 128'h0000_C6EE_FEFE_D6C6_C6C6_C6C6_0000_0000; // M
            default: glyph_s = 128'h0;
        endcase
        // Shift the selected row up to the top byte.
        row_sel_s = glyph_s << {addr_q[3:0], 3'b000};
        data_o    = row_sel_s[127:120];
    end

endmodule

// File: rtl/text_line_renderer.sv
// text_line_renderer: draws one line of NUM_CHARS ASCII cells at
// (ORIGIN_X, ORIGIN_Y), magnified by 2^SCALE_LOG2. The display reads an
// active buffer that frame_start reloads from the shadow buffer written by
// software. There is a two-stage pix_tick pipeline from pix_x/pix_y to the
// pix_on and text_region outputs.
// Optional feature macro: TEXT_LINE_RENDERER_BLINK_EN. This macro adds the
// blink_mask input and a 5-bit frame counter. Masked cells are blank while
// counter[4] is 1.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pix_tick            pipeline advance enable
//   pix_x, pix_y        current pixel coordinates
//   frame_start         commit shadow -> active (start of vertical blank)
//   wr_en/wr_idx/wr_code shadow buffer write port; wr_ack pulses per accepted write
//   blink_mask          (BLINK_EN only) per-cell blink enable, sampled at commit
//   pix_on, text_region registered render outputs
module text_line_renderer
    import text_line_renderer_pkg::*;
#(
    parameter int NUM_CHARS  = 8,
    parameter int SCALE_LOG2 = 0,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    localparam int IDX_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_tick,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CODE_W-1:0] wr_code,
`ifdef TEXT_LINE_RENDERER_BLINK_EN
    input  logic [NUM_CHARS-1:0] blink_mask,
`endif
    output logic              wr_ack,
    output logic              pix_on,
    output logic              text_region
);

    localparam int X_END = ORIGIN_X + NUM_CHARS * GLYPH_W * (1 << SCALE_LOG2);
    localparam int Y_END = ORIGIN_Y + GLYPH_H * (1 << SCALE_LOG2);
    // Pixel coordinates never exceed 1023, so clamping the end at 1024 keeps
    // the bounds in 11 bits without changing which pixels are inside.
    localparam logic [COORD_W-1:0] X_LO = COORD_W'(ORIGIN_X);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(ORIGIN_Y);
    localparam logic [COORD_W-1:0] X_HI = COORD_W'((X_END > 1024) ? 1024 : X_END);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'((Y_END > 1024) ? 1024 : Y_END);
    localparam logic [IDX_W:0]     NUM_CHARS_W = NUM_CHARS[IDX_W:0];

    logic [NUM_CHARS-1:0][CODE_W-1:0] shadow_q, shadow_d, active_q;
    logic                wr_ok_s, wr_ack_q;
    logic [COORD_W:0]    dx_w_s, dy_w_s;
    logic [COORD_W-1:0]  dx_s, dy_s;
    logic                in_box_s;
    logic [IDX_W-1:0]    cell_s;
    logic [2:0]          col_s, col_q;
    logic [3:0]          row_s;
    logic [CODE_W-1:0]   code_s;
    logic [GLYPH_W-1:0]  rom_data_s;
    logic                region_q, pix_on_q, text_region_q;

`ifdef TEXT_LINE_RENDERER_BLINK_EN
    logic [NUM_CHARS-1:0] blink_q;
    logic [4:0]           frame_cnt_q;

    // Blink mask is latched with each commit; the counter counts frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q     <= '0;
            frame_cnt_q <= 5'd0;
        end else if (frame_start) begin
            blink_q     <= blink_mask;
            frame_cnt_q <= frame_cnt_q + 5'd1;
        end else begin
            blink_q     <= blink_q;
            frame_cnt_q <= frame_cnt_q;
        end
    end
`endif

    // Shadow write decode; out-of-range indices are dropped.
    always_comb begin
        wr_ok_s  = wr_en && ({1'b0, wr_idx} < NUM_CHARS_W);
        shadow_d = shadow_q;
        if (wr_ok_s) begin
            shadow_d[wr_idx] = wr_code;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Character buffers; the commit uses shadow_d so a same-cycle write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= {NUM_CHARS{FILL_CODE}};
            active_q <= {NUM_CHARS{FILL_CODE}};
            wr_ack_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            wr_ack_q <= wr_ok_s;
            if (frame_start) begin
                active_q <= shadow_d;
            end else begin
                active_q <= active_q;
            end
        end
    end

    // Coordinate decode. The extra top bit of the subtraction is the borrow,
    // so it flags pixels left of / above the origin.
    always_comb begin
        dx_w_s   = {2'b00, pix_x} - {1'b0, X_LO};
        dy_w_s   = {2'b00, pix_y} - {1'b0, Y_LO};
        dx_s     = dx_w_s[COORD_W-1:0];
        dy_s     = dy_w_s[COORD_W-1:0];
        in_box_s = !dx_w_s[COORD_W] && ({1'b0, pix_x} < X_HI) &&
                   !dy_w_s[COORD_W] && ({1'b0, pix_y} < Y_HI);
        cell_s   = IDX_W'(dx_s >> (3 + SCALE_LOG2));
        col_s    = 3'(dx_s >> SCALE_LOG2);
        row_s    = 4'(dy_s >> SCALE_LOG2);
        if (in_box_s) begin
            code_s = active_q[cell_s];
        end else begin
            code_s = FILL_CODE;
        end
`ifdef TEXT_LINE_RENDERER_BLINK_EN
        // A blinking cell is shown as a space during the upper half of the count.
        if (in_box_s && blink_q[cell_s] && frame_cnt_q[4]) begin
            code_s = FILL_CODE;
        end else begin
            code_s = code_s;
        end
`endif
    end

    glyph_rom u_glyph_rom (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (pix_tick),
        .addr_i  (rom_addr(code_s, row_s)),
        .data_o  (rom_data_s)
    );

    // Render pipeline: stage 1 keeps column and region alongside the ROM
    // address register, stage 2 picks the column bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q         <= 3'd0;
            region_q      <= 1'b0;
            pix_on_q      <= 1'b0;
            text_region_q <= 1'b0;
        end else if (pix_tick) begin
            col_q         <= col_s;
            region_q      <= in_box_s;
            pix_on_q      <= region_q & rom_data_s[3'd7 - col_q];
            text_region_q <= region_q;
        end else begin
            col_q         <= col_q;
            region_q      <= region_q;
            pix_on_q      <= pix_on_q;
            text_region_q <= text_region_q;
        end
    end

    assign wr_ack      = wr_ack_q;
    assign pix_on      = pix_on_q;
    assign text_region = text_region_q;

endmodule

// File: tb/tb_text_line_renderer.sv
// Self-checking bench for text_line_renderer. Instance A uses the default
// parameters. Instance B uses NUM_CHARS=6, SCALE_LOG2=1 and ORIGIN_X=100.
// Both instances share their inputs.
module tb_text_line_renderer;

    logic       clk = 1'b0;
    logic       reset, pix_tick, frame_start, wr_en;
    logic [9:0] pix_x, pix_y;
    logic [2:0] wr_idx;
    logic [6:0] wr_code;
    logic       ack_a, on_a, reg_a, ack_b, on_b, reg_b;
`ifdef TEXT_LINE_RENDERER_BLINK_EN
    logic [7:0] mask_a;
    logic [5:0] mask_b;
`endif

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [4:0] fcnt = 5'd0;

    typedef struct {
        int   x;
        int   y;
        logic on;
        logic region;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    text_line_renderer u_a (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code),
`ifdef TEXT_LINE_RENDERER_BLINK_EN
        .blink_mask(mask_a),
`endif
        .wr_ack(ack_a), .pix_on(on_a), .text_region(reg_a)
    );

    text_line_renderer #(.NUM_CHARS(6), .SCALE_LOG2(1), .ORIGIN_X(100), .ORIGIN_Y(0)) u_b (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code),
`ifdef TEXT_LINE_RENDERER_BLINK_EN
        .blink_mask(mask_b),
`endif
        .wr_ack(ack_b), .pix_on(on_b), .text_region(reg_b)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold coordinates for two ticks so the outputs reflect them.
    task automatic probe(input int x, input int y);
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        pix_tick = 1'b1;
        step();
        step();
    endtask

    task automatic write(input int idx, input logic [6:0] code, input logic fs);
        wr_en       = 1'b1;
        wr_idx      = 3'(idx);
        wr_code     = code;
        frame_start = fs;
        step();
        wr_en       = 1'b0;
        frame_start = 1'b0;
        if (fs) fcnt++;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        fcnt++;
    endtask

    // Reference for instance A on y=4 with '0' in cell 3 and other cells 1..7 blank.
    function automatic logic model_on_a4(input int x);
        logic [7:0] pat;
        pat = 8'hC6;
        if (x >= 24 && x < 32) return pat[7 - (x - 24)];
        return 1'b0;
    endfunction

    initial begin
        logic [7:0] row;
        logic       t, exp_on, exp_reg;
        int         xs[$];
        int         nx;

        // Vectors for instance A after '0' is committed to cell 3.
        row = 8'hC6;
        for (int i = 0; i < 8; i++) tbl.push_back('{24 + i, 4, row[7 - i], 1'b1});
        tbl.push_back('{23, 4, 1'b0, 1'b1});
        tbl.push_back('{32, 4, 1'b0, 1'b1});
        tbl.push_back('{24, 3, 1'b1, 1'b1});
        tbl.push_back('{24, 1, 1'b0, 1'b1});
        tbl.push_back('{27, 13, 1'b0, 1'b1});
        tbl.push_back('{63, 15, 1'b0, 1'b1});
        tbl.push_back('{64, 15, 1'b0, 1'b0});
        tbl.push_back('{0, 16, 1'b0, 1'b0});
        tbl.push_back('{63, 16, 1'b0, 1'b0});
        tbl.push_back('{1023, 1023, 1'b0, 1'b0});

        reset = 1'b1; pix_tick = 1'b1; frame_start = 1'b0; wr_en = 1'b0;
        wr_idx = 3'd0; wr_code = 7'h00; pix_x = 10'd0; pix_y = 10'd0;
`ifdef TEXT_LINE_RENDERER_BLINK_EN
        mask_a = 8'h01;
        mask_b = 6'h00;
`endif
        step(); step(); step();
        chk("rst_on_a", on_a, 1'b0);  chk("rst_reg_a", reg_a, 1'b0);  chk("rst_ack_a", ack_a, 1'b0);
        chk("rst_on_b", on_b, 1'b0);  chk("rst_reg_b", reg_b, 1'b0);  chk("rst_ack_b", ack_b, 1'b0);
        reset = 1'b0;

        // All spaces: nothing lit, region only inside the 64x16 box.
        for (int y = 0; y < 18; y++) begin
            for (int x = 0; x < 67; x++) begin
                probe(x, y);
                chk("scan_on", on_a, 1'b0);
                chk("scan_reg", reg_a, (x < 64) && (y < 16));
            end
        end

        // Write without a commit: one ack, display unchanged.
        write(3, 7'h30, 1'b0);
        chk("ack_pulse", ack_a, 1'b1);
        step();
        chk("ack_once", ack_a, 1'b0);
        probe(24, 4); chk("precommit_24", on_a, 1'b0);
        probe(25, 4); chk("precommit_25", on_a, 1'b0);
        commit();
        for (int i = 0; i < tbl.size(); i++) begin
            probe(tbl[i].x, tbl[i].y);
            chk("tbl_on", on_a, tbl[i].on);
            chk("tbl_reg", reg_a, tbl[i].region);
        end

        // Scaled instance: '1' in cell 0, glyph row 2 = 00011000.
        write(0, 7'h31, 1'b0);
        commit();
        for (int y = 4; y < 6; y++) begin
            for (int x = 100; x < 116; x++) begin
                probe(x, y);
                chk("scale_on", on_b, (x >= 106) && (x <= 109));
                chk("scale_reg", reg_b, 1'b1);
            end
        end
        probe(99, 4);   chk("b_left_reg", reg_b, 1'b0);
        probe(195, 31); chk("b_corner_reg", reg_b, 1'b1);
        probe(196, 31); chk("b_right_reg", reg_b, 1'b0);
        probe(195, 32); chk("b_below_reg", reg_b, 1'b0);
        probe(3, 2);    chk("a_one_on", on_a, 1'b1);
        probe(2, 2);    chk("a_one_off", on_a, 1'b0);

        // Streaming with pix_tick gaps; coordinates change to 0 during gaps.
        nx = 20; exp_on = 1'b0; exp_reg = 1'b0;
        for (int i = 0; i < 80; i++) begin
            t        = (i % 4 != 3) && (i % 7 != 5);
            pix_tick = t;
            pix_x    = t ? 10'(nx) : 10'd0;
            pix_y    = 10'd4;
            step();
            if (t) begin
                xs.push_back(nx);
                nx++;
                if (xs.size() >= 2) begin
                    exp_on  = model_on_a4(xs[xs.size() - 2]);
                    exp_reg = (xs[xs.size() - 2] < 64);
                end
            end
            if (xs.size() >= 2) begin
                chk("stream_on", on_a, exp_on);
                chk("stream_reg", reg_a, exp_reg);
            end
        end
        pix_tick = 1'b1;

        // Index 6 is valid for A (8 cells) but out of range for B (6 cells).
        write(6, 7'h38, 1'b0);
        chk("idx6_ack_a", ack_a, 1'b1);
        chk("idx6_ack_b", ack_b, 1'b0);
        commit();
        for (int c = 0; c < 6; c++) begin
            probe(100 + 16 * c, 8);
            chk("b_cells", on_b, c == 3);
        end
        probe(48, 4); chk("a_cell6", on_a, 1'b1);

        // Write in the commit cycle is shown in the new frame.
        write(1, 7'h41, 1'b1);
        probe(8, 5);    chk("same_a8", on_a, 1'b1);
        probe(9, 5);    chk("same_a9", on_a, 1'b1);
        probe(10, 5);   chk("same_a10", on_a, 1'b0);
        probe(116, 10); chk("same_b116", on_b, 1'b1);
        probe(120, 10); chk("same_b120", on_b, 1'b0);

`ifdef TEXT_LINE_RENDERER_BLINK_EN
        // Cell 0 blinks: blank while the frame count is 16..31.
        for (int f = 0; f < 40; f++) begin
            commit();
            probe(3, 2);  chk("blink_cell0", on_a, ~fcnt[4]);
            probe(24, 4); chk("blink_cell3", on_a, 1'b1);
        end
`endif

        // Reset wins over a write, a commit and a tick in the same cycle.
        probe(24, 4); chk("prereset_on", on_a, 1'b1);
        reset = 1'b1; wr_en = 1'b1; wr_idx = 3'd2; wr_code = 7'h38; frame_start = 1'b1;
        step();
        chk("midrst_on", on_a, 1'b0);
        chk("midrst_reg", reg_a, 1'b0);
        chk("midrst_ack", ack_a, 1'b0);
        reset = 1'b0; wr_en = 1'b0; frame_start = 1'b0; fcnt = 5'd0;
        probe(24, 4); chk("postrst_on", on_a, 1'b0); chk("postrst_reg", reg_a, 1'b1);
        commit();
        probe(16, 4); chk("postrst_nowrite", on_a, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
